// File: rtl/brushless_comm.sv
// Brushless commutation controller: synchronizes the hall sensors and the
// brake request, samples rotor position once per PWM period, and drives the
// per-phase selects and duty into the driver stage one clock after each sample.
module brushless_comm #(
    parameter int unsigned STALL_CNT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic [11:0] drv_mag,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        hall_err,
    output logic        stall
);

    localparam logic [15:0] STALL_LIM  = 16'(STALL_CNT);
    localparam logic [10:0] DUTY_BRAKE = 11'h600;
    localparam logic [10:0] DUTY_BASE  = 11'h400;

    logic [2:0]  hall_meta;
    logic [2:0]  hall_sync;
    logic        brake_meta;
    logic        brake_sync;

    logic [2:0]  rot_state;
    logic [2:0]  prev_state;
    logic [15:0] stall_cnt;
    logic [11:0] mag_q;
    logic        upd_pend;

    logic        rot_invalid;
    logic        rot_adjacent;
    logic        err_c;
    logic        stall_hit;
    logic [5:0]  table_sel;

    // Successor of a hall code in the forward rotation sequence; 000 for invalid codes.
    function automatic logic [2:0] fwd_next(input logic [2:0] s);
        case (s)
            3'b101:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b001;
            3'b001:  fwd_next = 3'b101;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    // Commutation table, {selGrn, selYlw, selBlu}.
    function automatic logic [5:0] comm_sel(input logic [2:0] s);
        case (s)
            3'b101:  comm_sel = 6'b10_01_00;
            3'b100:  comm_sel = 6'b10_00_01;
            3'b110:  comm_sel = 6'b00_10_01;
            3'b010:  comm_sel = 6'b01_10_00;
            3'b011:  comm_sel = 6'b01_00_10;
            3'b001:  comm_sel = 6'b00_01_10;
            default: comm_sel = 6'b00_00_00;
        endcase
    endfunction

    // Two-flop synchronizers; brake resets to the not-braking level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_meta  <= 3'b000;
            hall_sync  <= 3'b000;
            brake_meta <= 1'b1;
            brake_sync <= 1'b1;
        end else begin
            hall_meta  <= {hallGrn, hallYlw, hallBlu};
            hall_sync  <= hall_meta;
            brake_meta <= brake_n;
            brake_sync <= brake_meta;
        end
    end

    // Per-period sample of rotor position, stall counting, and the pending-update flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_state  <= 3'b000;
            prev_state <= 3'b000;
            stall_cnt  <= 16'd0;
            mag_q      <= 12'd0;
            upd_pend   <= 1'b0;
        end else begin
            upd_pend <= PWM_synch;
            if (PWM_synch) begin
                rot_state  <= hall_sync;
                prev_state <= rot_state;
                mag_q      <= drv_mag;
                if ((hall_sync != rot_state) || (drv_mag == 12'd0)) begin
                    stall_cnt <= 16'd0;
                end else if (stall_cnt != STALL_LIM) begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
            end
        end
    end

    // Invalid codes never match a valid successor, so adjacency needs no separate validity test.
    assign rot_invalid  = (rot_state == 3'b000) || (rot_state == 3'b111);
    assign rot_adjacent = (fwd_next(prev_state) == rot_state) || (fwd_next(rot_state) == prev_state);
    assign err_c        = rot_invalid || ((rot_state != prev_state) && !rot_adjacent);
    assign stall_hit    = (stall_cnt == STALL_LIM);
    assign table_sel    = comm_sel(rot_state);

    // Driver-facing outputs change only on the clock after a sample, in priority order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selGrn   <= 2'b00;
            selYlw   <= 2'b00;
            selBlu   <= 2'b00;
            duty     <= 11'd0;
            hall_err <= 1'b0;
            stall    <= 1'b0;
        end else if (upd_pend) begin
            hall_err <= err_c;
            stall    <= stall_hit;
            if (!brake_sync) begin
                {selGrn, selYlw, selBlu} <= 6'b11_11_11;
                duty                     <= DUTY_BRAKE;
            end else if (stall_hit || rot_invalid) begin
                {selGrn, selYlw, selBlu} <= 6'b00_00_00;
                duty                     <= 11'd0;
            end else begin
                {selGrn, selYlw, selBlu} <= table_sel;
                duty                     <= DUTY_BASE + {1'b0, mag_q[11:2]};
            end
        end
    end

endmodule

// File: tb/tb_brushless_comm.sv
// Testbench for brushless_comm: directed vector table, reset corner cases,
// then randomized periods checked against a behavioural model.
module tb_brushless_comm;

    localparam int STALL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        hallGrn, hallYlw, hallBlu;
    logic        brake_n;
    logic [11:0] drv_mag;
    logic        PWM_synch;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        hall_err;
    logic        stall;

    brushless_comm #(.STALL_CNT(STALL)) dut (
        .clk(clk), .rst(rst),
        .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .brake_n(brake_n), .drv_mag(drv_mag), .PWM_synch(PWM_synch),
        .duty(duty), .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .hall_err(hall_err), .stall(stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  hall;
        logic        brk_n;
        logic [11:0] mag;
        logic [5:0]  sel;
        logic [10:0] duty;
        logic        err;
        logic        stl;
    } vec_t;

    vec_t vecs[$];

    // Forward rotation order and the matching drive pattern at each position.
    logic [2:0] seq_code [6];
    logic [5:0] seq_sel  [6];

    // Behavioural model state
    logic [2:0]  m_cur, m_prev;
    int          m_cnt;
    logic [5:0]  e_sel;
    logic [10:0] e_duty;
    logic        e_err, e_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [2:0] h, input logic bn, input logic [11:0] mg,
                           input logic [5:0] s, input logic [10:0] d, input logic e, input logic st);
        vec_t v;
        v.hall = h; v.brk_n = bn; v.mag = mg; v.sel = s; v.duty = d; v.err = e; v.stl = st;
        vecs.push_back(v);
    endtask

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (seq_code[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = 3'b000; m_prev = 3'b000; m_cnt = 0;
        e_sel = 6'd0; e_duty = 11'd0; e_err = 1'b0; e_stall = 1'b0;
    endtask

    task automatic model_sample(input logic [2:0] h, input logic bn, input logic [11:0] mg);
        int pc, pp, d;
        bit changed;
        changed = (h != m_cur);
        m_prev  = m_cur;
        m_cur   = h;
        if (changed || mg == 0) m_cnt = 0;
        else if (m_cnt < STALL) m_cnt = m_cnt + 1;
        pc = pos_of(m_cur);
        pp = pos_of(m_prev);
        d  = (pc - pp + 6) % 6;
        e_err   = (pc < 0) || ((m_cur != m_prev) && (pp < 0 || !(d == 1 || d == 5)));
        e_stall = (m_cnt == STALL);
        if (!bn) begin
            e_sel = 6'b111111; e_duty = 11'h600;
        end else if (e_stall || pc < 0) begin
            e_sel = 6'd0; e_duty = 11'd0;
        end else begin
            e_sel  = seq_sel[pc];
            e_duty = 11'(1024 + (int'(mg) / 4));
        end
    endtask

    // One PWM period: apply inputs, let them settle, pulse PWM_synch, check at E+1.
    task automatic do_sample(input logic [2:0] h, input logic bn, input logic [11:0] mg);
        @(negedge clk);
        {hallGrn, hallYlw, hallBlu} = h;
        brake_n = bn;
        drv_mag = mg;
        repeat (4) @(negedge clk);
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        check("hold_sel", {selGrn, selYlw, selBlu}, e_sel);
        check("hold_duty", duty, e_duty);
        model_sample(h, bn, mg);
        @(posedge clk);
        #1;
        check("model_sel", {selGrn, selYlw, selBlu}, e_sel);
        check("model_duty", duty, e_duty);
        check("model_err", hall_err, e_err);
        check("model_stall", stall, e_stall);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_sel"}, {selGrn, selYlw, selBlu}, 6'd0);
        check({name, "_duty"}, duty, 11'd0);
        check({name, "_err"}, hall_err, 1'b0);
        check({name, "_stall"}, stall, 1'b0);
    endtask

    initial begin
        logic [2:0] h;
        logic       bn;
        logic [11:0] mg;
        int         p;

        seq_code[0] = 3'b101; seq_sel[0] = 6'b10_01_00;
        seq_code[1] = 3'b100; seq_sel[1] = 6'b10_00_01;
        seq_code[2] = 3'b110; seq_sel[2] = 6'b00_10_01;
        seq_code[3] = 3'b010; seq_sel[3] = 6'b01_10_00;
        seq_code[4] = 3'b011; seq_sel[4] = 6'b01_00_10;
        seq_code[5] = 3'b001; seq_sel[5] = 6'b00_01_10;

        // hall, brake_n, drv_mag, {selG,selY,selB}, duty, hall_err, stall
        add_vec(3'b000, 1, 12'h800, 6'b00_00_00, 11'h000, 1, 0);
        add_vec(3'b101, 1, 12'h800, 6'b10_01_00, 11'h600, 1, 0);
        add_vec(3'b101, 1, 12'h800, 6'b10_01_00, 11'h600, 0, 0);
        add_vec(3'b100, 1, 12'h800, 6'b10_00_01, 11'h600, 0, 0);
        add_vec(3'b110, 1, 12'h800, 6'b00_10_01, 11'h600, 0, 0);
        add_vec(3'b010, 1, 12'h800, 6'b01_10_00, 11'h600, 0, 0);
        add_vec(3'b011, 1, 12'h800, 6'b01_00_10, 11'h600, 0, 0);
        add_vec(3'b001, 1, 12'h800, 6'b00_01_10, 11'h600, 0, 0);
        add_vec(3'b101, 1, 12'h800, 6'b10_01_00, 11'h600, 0, 0);
        add_vec(3'b110, 1, 12'h800, 6'b00_10_01, 11'h600, 1, 0);
        add_vec(3'b010, 1, 12'h800, 6'b01_10_00, 11'h600, 0, 0);
        add_vec(3'b111, 1, 12'h800, 6'b00_00_00, 11'h000, 1, 0);
        add_vec(3'b011, 1, 12'h800, 6'b01_00_10, 11'h600, 1, 0);
        add_vec(3'b011, 0, 12'h800, 6'b11_11_11, 11'h600, 0, 0);
        add_vec(3'b011, 1, 12'h100, 6'b01_00_10, 11'h440, 0, 0);
        for (int i = 0; i < 5; i++)
            add_vec(3'b011, 1, 12'h100, 6'b01_00_10, 11'h440, 0, 0);
        add_vec(3'b011, 1, 12'h100, 6'b00_00_00, 11'h000, 0, 1);
        add_vec(3'b011, 0, 12'h100, 6'b11_11_11, 11'h600, 0, 1);
        add_vec(3'b001, 1, 12'h100, 6'b00_01_10, 11'h440, 0, 0);
        for (int i = 0; i < 10; i++)
            add_vec(3'b001, 1, 12'h000, 6'b00_01_10, 11'h400, 0, 0);

        rst = 1'b1;
        {hallGrn, hallYlw, hallBlu} = 3'b000;
        brake_n = 1'b1;
        drv_mag = 12'd0;
        PWM_synch = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_sample(vecs[i].hall, vecs[i].brk_n, vecs[i].mag);
            check($sformatf("vec%0d_sel", i), {selGrn, selYlw, selBlu}, vecs[i].sel);
            check($sformatf("vec%0d_duty", i), duty, vecs[i].duty);
            check($sformatf("vec%0d_err", i), hall_err, vecs[i].err);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].stl);
        end

        // Asynchronous reset while driving 10/01/00
        do_sample(3'b101, 1, 12'h800);
        do_sample(3'b101, 1, 12'h800);
        check("pre_rst_sel", {selGrn, selYlw, selBlu}, 6'b10_01_00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset landing between E and E+1 discards the pending update
        do_sample(3'b101, 1, 12'h800);
        {hallGrn, hallYlw, hallBlu} = 3'b100;
        repeat (4) @(negedge clk);
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        model_reset();

        // Randomized periods against the model
        h = 3'b101;
        for (int n = 0; n < 120; n++) begin
            p = pos_of(h);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: h = h;
                4, 5:       h = (p < 0) ? 3'b101 : seq_code[(p + 1) % 6];
                6, 7:       h = (p < 0) ? 3'b001 : seq_code[(p + 5) % 6];
                default:    h = 3'($urandom_range(0, 7));
            endcase
            bn = ($urandom_range(0, 7) != 0);
            mg = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom);
            do_sample(h, bn, mg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brushless_comm.md
# brushless_comm

Commutation controller that sits directly upstream of the motor driver stage. Synchronizes the three asynchronous hall-effect inputs and latches the rotor position once per PWM period on `PWM_synch`. Produces the per-phase 2-bit drive selects (`selGrn`/`selYlw`/`selBlu`) and the 11-bit `duty` that the driver consumes. Also handles braking, invalid hall codes and stall detection.

## Interface
Parameters:
- `STALL_CNT`, 1024: number of PWM periods without a hall transition, while torque is requested, before stall is declared (1..65535).

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `hallGrn`, `hallYlw`, `hallBlu` input 1 each: raw hall sensor levels, asynchronous to `clk`.
- `brake_n` input 1: active-low brake request, asynchronous.
- `drv_mag` input 12: requested drive magnitude, unsigned, synchronous.
- `PWM_synch` input 1: one-`clk` pulse per PWM period, from the driver stage.
- `duty` output 11: PWM duty to the driver.
- `selGrn`, `selYlw`, `selBlu` output 2 each: phase select. 00 = high-Z, 01 = reverse current, 10 = forward current, 11 = brake.
- `hall_err` output 1: high while the latched hall code is invalid or the last transition skipped a step.
- `stall` output 1: high while stall is declared.

## Operation
- Each hall input and `brake_n` passes through a two-flop synchronizer. Synchronizer flops reset to 0. The `brake_n` synchronizer resets to 1, meaning not braking.
- `rot_state[2:0] = {Grn,Ylw,Blu}` loads from the synchronized halls only on edges where `PWM_synch` = 1. `prev_state` takes the old `rot_state` on the same edge.
- Commutation table, in selGrn/selYlw/selBlu order:
  - 101: 10/01/00
  - 100: 10/00/01
  - 110: 00/10/01
  - 010: 01/10/00
  - 011: 01/00/10
  - 001: 00/01/10
  - 000 or 111 (invalid): 00/00/00
- Forward sequence is 101→100→110→010→011→001→101. Reverse sequence is the same in the opposite direction; both directions are legal.
- `hall_err` is 1 if `rot_state` is invalid. It is also 1 if `rot_state` ≠ `prev_state` and the new state is not one step away from the old one in either direction. It clears on the next sample that is valid and either adjacent or unchanged.
- Stall counter, 16 bits, saturating at `STALL_CNT`:
  - On each `PWM_synch` sample it clears if `rot_state` changed or `drv_mag` = 0. Otherwise it increments.
  - `stall` = 1 when the counter equals `STALL_CNT`.
  - `stall` clears at the update following a hall change or `drv_mag` = 0.
- Output priority, highest first:
  1. Brake (sync `brake_n` = 0): all selects 11, `duty` = 11'h600.
  2. Stall: all selects 00, `duty` = 0.
  3. Invalid `rot_state`: all selects 00, `duty` = 0.
  4. Normal: selects from the table; `duty` = 11'h400 + `drv_mag[11:2]`. This is an 11-bit add of a 10-bit zero-extended operand, cannot overflow, max 11'h7FF.

## Timing
- At edge E with `PWM_synch` = 1, `rot_state`, `prev_state` and the stall counter update.
- At edge E+1, the `sel*`, `duty`, `hall_err` and `stall` registers update from the values produced at E and the current sync `brake_n`.
- Outputs never change at any other edge, so there are no mid-period glitches into the driver.
- Hall pin change to `sel*` change: 2 synchronizer clocks, then wait for the next `PWM_synch`, then +1 clock.
- Reset values: all `sel*` = 00, `duty` = 0, `hall_err` = 0, `stall` = 0, `rot_state` = `prev_state` = 000, counter = 0.
- The first post-reset sample with halls 000 raises `hall_err` at E+1. This is expected.
- `rst` asserted at any point, including between E and E+1: all registers return to reset values immediately and asynchronously. The pending E+1 update is discarded.
- Brake applied or released between `PWM_synch` pulses takes effect only at the next E+1.
- If `PWM_synch` is held high for multiple cycles, each such edge is a sample (no edge detection is done). The driver guarantees single-cycle pulses.

## Test plan
- **Reset:** assert `rst` mid-run with selects at 10/01/00. Required: all outputs return to reset values within the same cycle, asynchronously.
- **Forward rotation:** `drv_mag` = 12'h800, step halls 101→100→110→010→011→001, one state per 4 PWM periods. Required: selects follow the table exactly 1 clk after the first `PWM_synch` after each hall change (plus 2 sync clocks); `duty` = 11'h600; `hall_err` stays 0.
- **Sequence error:** jump halls 101→110. Required: `hall_err` = 1 at E+1 and selects = 00/10/01. Then step to 010: `hall_err` = 0.
- **Invalid code:** halls = 111. Required: selects 00/00/00, `duty` = 0, `hall_err` = 1.
- **Brake:** `brake_n` = 0 with halls at a valid code. Required: all selects 11, `duty` = 11'h600 at the first E+1 after synchronization; brake takes priority over a simultaneous stall.
- **Stall:** `STALL_CNT` = 8, `drv_mag` = 12'h100, halls static at 011. Required: `stall` = 1 at E+1 of the 8th sample, with selects 00 and `duty` = 0. Changing halls to 001 clears `stall` and resumes the table output at the next update. With `drv_mag` = 0, `stall` never asserts.
